// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one step per clock.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       b_q;
    logic [2*WIDTH-1:0]     prod;

    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [WIDTH:0]         rem_sh;
    logic [WIDTH:0]         rem_diff;
    logic                   div_ge;
    logic [WIDTH-1:0]       rem_new;
    logic [2*WIDTH-1:0]     div_next;
    logic                   last;

    // One iteration of each algorithm, computed from the product register
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]}
                 + (prod[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};
        rem_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        div_ge   = (rem_sh >= {1'b0, b_q});
        rem_new  = div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        div_next = {rem_new, prod[WIDTH-2:0], div_ge};
    end

    assign last  = (cnt == CW'(WIDTH - 1));
    assign busy  = (state == MUL) || (state == DIV);
    assign done  = (state == DONE);
    assign stall = busy && (start || hilo_rd);

    // Sequencer FSM, operand/product datapath and HI/LO result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            prod  <= '0;
            hi    <= '0;
            lo    <= '0;
            dz    <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        cnt <= '0;
                        if (!op) begin
                            state <= MUL;
                            prod  <= {{WIDTH{1'b0}}, b};
                        end else if (b != '0) begin
                            state <= DIV;
                            prod  <= {{WIDTH{1'b0}}, a};
                        end else begin
                            // Divide by zero completes immediately
                            state <= DONE;
                            hi    <= a;
                            lo    <= '1;
                            dz    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        hi    <= mul_next[2*WIDTH-1:WIDTH];
                        lo    <= mul_next[WIDTH-1:0];
                        dz    <= 1'b0;
                    end
                end
                DIV: begin
                    prod <= div_next;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        hi    <= div_next[2*WIDTH-1:WIDTH];
                        lo    <= div_next[WIDTH-1:0];
                        dz    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (WIDTH = 32).
// Vector table, random ops against a reference model, multi-cycle corners.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        abort = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        busy, done, dz, stall;
    logic [31:0] hi, lo;

    int total = 0;
    int bad = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .abort(abort), .hilo_rd(hilo_rd),
        .busy(busy), .done(done), .hi(hi), .lo(lo),
        .dz(dz), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {dz, hi, lo} from plain arithmetic
    function automatic logic [64:0] model(input logic o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] p;
        if (!o) begin
            p = 64'(x) * 64'(y);
            return {1'b0, p};
        end
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
    endfunction

    // Present start for one edge, then scramble operands
    task automatic issue(input logic o, input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = $urandom_range(0, 1);
    endtask

    // Cycles from acceptance edge until done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic o,
                             input logic [31:0] x, input logic [31:0] y);
        logic [64:0] r;
        int lat;
        r = model(o, x, y);
        issue(o, x, y);
        wait_done(lat);
        check({name, "_lat"}, 64'(lat), 64'((o && y == 0) ? 1 : 33));
        check({name, "_hilo"}, {hi, lo}, r[63:0]);
        check({name, "_dz"}, 64'(dz), 64'(r[64]));
        @(posedge clk);
        #1;
        check({name, "_pulse"}, 64'({done, busy}), 64'(0));
    endtask

    initial begin
        int lat;
        int cnt;
        logic [64:0] r;

        vecs[0] = '{1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 33};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h1, 1'b0, 33};
        vecs[2] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33};
        vecs[3] = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[4] = '{1'b0, 32'd0, 32'd123, 32'h0, 32'h0, 1'b0, 33};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 32'h0,
                    32'hFFFF_FFFF, 1'b0, 33};
        vecs[6] = '{1'b1, 32'd3, 32'd10, 32'd3, 32'd0, 1'b0, 33};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {hi, lo}, 64'h0);
        check("rst_flags", 64'({busy, done, dz, stall}), 64'(0));
        reset = 1'b1;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_hilo", i), {hi, lo},
                  {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_idle", i), 64'({done, busy}), 64'(0));
        end

        // Random ops against the model
        for (int i = 0; i < 24; i++) begin
            logic o;
            logic [31:0] x, y;
            o = $urandom_range(0, 1);
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
            run_check($sformatf("rnd%0d", i), o, x, y);
        end

        // Stall with hilo_rd held through a multiply
        hilo_rd = 1'b1;
        issue(1'b0, 32'd9, 32'd9);
        cnt = 0;
        lat = 1;
        while (!done && lat < 100) begin
            if (stall) cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_cycles", 64'(cnt), 64'(32));
        check("stall_done", 64'(stall), 64'(0));
        check("stall_res", {hi, lo}, 64'd81);
        hilo_rd = 1'b0;
        @(posedge clk);
        #1;

        // Start while busy is ignored
        issue(1'b0, 32'd1000, 32'd1000);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        op = 1'b1;
        a = 32'd50;
        b = 32'd0;
        #1;
        check("busy_stall", 64'(stall), 64'(1));
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_ign_lat", 64'(lat), 64'(33));
        check("busy_ign_res", {hi, lo}, 64'd1000000);
        @(posedge clk);
        #1;

        // Back-to-back start in DONE
        issue(1'b0, 32'd12, 32'd13);
        wait_done(lat);
        check("b2b_first", {hi, lo}, 64'd156);
        issue(1'b1, 32'd77, 32'd8);
        check("b2b_nobubble", 64'({busy, done}), 64'(2));
        wait_done(lat);
        check("b2b_lat", 64'(lat), 64'(33));
        check("b2b_res", {hi, lo}, {32'd5, 32'd9});
        @(posedge clk);
        #1;

        // Abort at iteration 10 of a divide
        run_check("pre_abort", 1'b1, 32'd23, 32'd5);
        issue(1'b1, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_idle", 64'({busy, done}), 64'(0));
        check("abort_hilo", {hi, lo}, {32'd3, 32'd4});
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) cnt++;
            @(posedge clk);
            #1;
        end
        check("abort_quiet", 64'(cnt), 64'(0));

        // Reset in the middle of a multiply
        run_check("pre_rst", 1'b1, 32'd9, 32'd0);
        issue(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        check("rst_mid_hilo", {hi, lo}, 64'h0);
        check("rst_mid_flags", 64'({busy, done, dz, stall}), 64'(0));
        r = model(1'b0, 32'd7, 32'd6);
        issue(1'b0, 32'd7, 32'd6);
        wait_done(lat);
        check("rst_after_lat", 64'(lat), 64'(33));
        check("rst_after_res", {hi, lo}, r[63:0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
